// File: rtl/cpu_pkg.sv
// Shared decode definitions for the decode stage: opcode constants,
// instruction field positions, FSM state encoding and the decoded record.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;

  // Instruction field bit positions (MIPS32 layout)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  // EMPTY: nothing held; FULL: holding, no hazard; STALL: holding a load
  // that the incoming instruction depends on.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_STALL = 2'b10
  } state_t;

  // Everything the stage hands to execute for one instruction.
  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  write_reg;
    logic        mem_read;
  } decoded_t;

  function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an incoming instruction that reads the
// register a held load is about to write. Register 0 never conflicts.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       in_valid,
  input  logic [4:0] in_rs,
  input  logic [4:0] in_rt,
  input  logic       held_valid,
  input  logic       held_mem_read,
  input  logic [4:0] held_rt,
  output logic       hazard
);

  assign hazard = in_valid && held_valid && held_mem_read &&
                  (held_rt != 5'd0) &&
                  ((held_rt == in_rs) || (held_rt == in_rt));

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage with valid/ready handshakes on both sides, single-bubble
// load-use interlock and a saturating stall counter.
// Optional feature: define WB_FORWARD_EN to forward the writeback port into
// the operands captured on accept.
module decode_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        InValid,
  input  logic [31:0] Instruction,
  output logic        InReady,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        WbWriteSignal,
  input  logic [4:0]  WbWriteRegister,
  input  logic [31:0] WbWriteData,
  input  logic        Flush,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutA,
  output logic [31:0] OutB,
  output logic [31:0] OutImm,
  output logic [5:0]  OutOpcode,
  output logic [5:0]  OutFunct,
  output logic [4:0]  OutRs,
  output logic [4:0]  OutRt,
  output logic [4:0]  OutWriteReg,
  output logic        OutMemRead,
  output logic [15:0] StallCount
);

  state_t      state_r;
  state_t      state_nxt;
  decoded_t    held_r;
  decoded_t    decoded;
  logic [15:0] stall_count_r;
  logic        hazard;
  logic        accept;
  logic        consume;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [5:0]  in_opcode;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;

  assign in_rs     = Instruction[RS_MSB:RS_LSB];
  assign in_rt     = Instruction[RT_MSB:RT_LSB];
  assign in_opcode = Instruction[OPCODE_MSB:OPCODE_LSB];

  assign ReadRegister1 = in_rs;
  assign ReadRegister2 = in_rt;

  assign OutValid = (state_r != ST_EMPTY);

  hazard_detect u_hazard (
    .in_valid      (InValid),
    .in_rs         (in_rs),
    .in_rt         (in_rt),
    .held_valid    (OutValid),
    .held_mem_read (held_r.mem_read),
    .held_rt       (held_r.write_reg),
    .hazard        (hazard)
  );

  assign InReady = !hazard && (!OutValid || OutReady);
  // Flush wins over accept, so a flushed cycle never captures the input.
  assign accept  = InValid && InReady && !Flush;
  assign consume = OutValid && OutReady;

`ifdef WB_FORWARD_EN
  // Operand select: take the value being written back this cycle when it
  // targets the register being read, otherwise the register-file data.
  always_comb begin
    opnd_a = ReadData1;
    opnd_b = ReadData2;
    if (WbWriteSignal && (WbWriteRegister != 5'd0) && (WbWriteRegister == in_rs)) begin
      opnd_a = WbWriteData;
    end else begin
      opnd_a = ReadData1;
    end
    if (WbWriteSignal && (WbWriteRegister != 5'd0) && (WbWriteRegister == in_rt)) begin
      opnd_b = WbWriteData;
    end else begin
      opnd_b = ReadData2;
    end
  end
`else
  assign opnd_a = ReadData1;
  assign opnd_b = ReadData2;
  logic unused_wb;
  assign unused_wb = ^{WbWriteSignal, WbWriteRegister, WbWriteData};
`endif

  // Field extraction for the instruction currently presented by fetch.
  always_comb begin
    decoded           = '0;
    decoded.op_a      = opnd_a;
    decoded.op_b      = opnd_b;
    decoded.imm       = sign_extend16(Instruction[IMM_MSB:IMM_LSB]);
    decoded.opcode    = in_opcode;
    decoded.funct     = Instruction[FUNCT_MSB:FUNCT_LSB];
    decoded.rs        = in_rs;
    decoded.rt        = in_rt;
    decoded.mem_read  = (in_opcode == OP_LW);
    if (in_opcode == OP_RTYPE) begin
      decoded.write_reg = Instruction[RD_MSB:RD_LSB];
    end else begin
      decoded.write_reg = in_rt;
    end
  end

  // Next-state logic: flush > accept > consume > hold.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_FULL;
        end else begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL, ST_STALL: begin
        if (Flush) begin
          state_nxt = ST_EMPTY;
        end else if (accept) begin
          state_nxt = ST_FULL;
        end else if (consume) begin
          state_nxt = ST_EMPTY;
        end else if (hazard) begin
          state_nxt = ST_STALL;
        end else begin
          state_nxt = ST_FULL;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // State register; reset discards anything held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Output record: loads only on accept, so it is frozen while back-pressured.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_r <= '0;
    end else if (accept) begin
      held_r <= decoded;
    end else begin
      held_r <= held_r;
    end
  end

  // Stall counter: one count per cycle the load-use interlock holds fetch, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= 16'd0;
    end else if (hazard && (stall_count_r != 16'hFFFF)) begin
      stall_count_r <= stall_count_r + 16'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign OutA        = held_r.op_a;
  assign OutB        = held_r.op_b;
  assign OutImm      = held_r.imm;
  assign OutOpcode   = held_r.opcode;
  assign OutFunct    = held_r.funct;
  assign OutRs       = held_r.rs;
  assign OutRt       = held_r.rt;
  assign OutWriteReg = held_r.write_reg;
  assign OutMemRead  = held_r.mem_read;
  assign StallCount  = stall_count_r;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed stimulus plus a negedge scoreboard
// that predicts handshakes, held fields and the stall counter.
module tb_decode_stage;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        in_ready;
  logic [4:0]  rd_reg1, rd_reg2;
  logic [31:0] rd_data1, rd_data2;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b, out_imm;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_wr;
  logic        out_mr;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        mr;
  } exp_t;

  exp_t        sb[$];
  exp_t        front;
  logic        m_valid;
  logic        m_hazard;
  logic        m_ready;
  logic [15:0] m_count = 16'd0;

  decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .InValid         (in_valid),
    .Instruction     (instr),
    .InReady         (in_ready),
    .ReadRegister1   (rd_reg1),
    .ReadRegister2   (rd_reg2),
    .ReadData1       (rd_data1),
    .ReadData2       (rd_data2),
    .WbWriteSignal   (wb_we),
    .WbWriteRegister (wb_reg),
    .WbWriteData     (wb_data),
    .Flush           (flush),
    .OutValid        (out_valid),
    .OutReady        (out_ready),
    .OutA            (out_a),
    .OutB            (out_b),
    .OutImm          (out_imm),
    .OutOpcode       (out_opcode),
    .OutFunct        (out_funct),
    .OutRs           (out_rs),
    .OutRt           (out_rt),
    .OutWriteReg     (out_wr),
    .OutMemRead      (out_mr),
    .StallCount      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic ws,
                                        input logic [4:0] wreg, input logic [31:0] wdata);
    exp_t e;
    e.op  = ins[31:26];
    e.rs  = ins[25:21];
    e.rt  = ins[20:16];
    e.fn  = ins[5:0];
    e.wr  = (ins[31:26] == 6'b000000) ? ins[15:11] : ins[20:16];
    e.imm = {{16{ins[15]}}, ins[15:0]};
    e.mr  = (ins[31:26] == 6'b100011);
    e.a   = d1;
    e.b   = d2;
    if (FWD && ws && (wreg != 5'd0) && (wreg == ins[25:21])) e.a = wdata;
    if (FWD && ws && (wreg != 5'd0) && (wreg == ins[20:16])) e.b = wdata;
    return e;
  endfunction

  // Scoreboard: checks this cycle against the prediction, then advances it.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      m_count = 16'd0;
    end else begin
      m_valid  = (sb.size() != 0);
      if (m_valid) front = sb[0];
      m_hazard = in_valid && m_valid && front.mr && (front.wr != 5'd0) &&
                 ((front.wr == instr[25:21]) || (front.wr == instr[20:16]));
      m_ready  = !m_hazard && (!m_valid || out_ready);
      check("out_valid", out_valid, m_valid);
      check("in_ready", in_ready, m_ready);
      check("stall_count", stall_count, m_count);
      check("read_reg1", rd_reg1, instr[25:21]);
      check("read_reg2", rd_reg2, instr[20:16]);
      if (m_valid) begin
        check("out_a", out_a, front.a);
        check("out_b", out_b, front.b);
        check("out_imm", out_imm, front.imm);
        check("out_opcode", out_opcode, front.op);
        check("out_funct", out_funct, front.fn);
        check("out_rs", out_rs, front.rs);
        check("out_rt", out_rt, front.rt);
        check("out_wr", out_wr, front.wr);
        check("out_mr", out_mr, front.mr);
        if (flush || out_ready) void'(sb.pop_front());
      end
      if (in_valid && m_ready && !flush)
        sb.push_back(model_decode(instr, rd_data1, rd_data2, wb_we, wb_reg, wb_data));
      if (m_hazard && (m_count != 16'hFFFF)) m_count = m_count + 16'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic v, input logic [31:0] ins, input logic [31:0] d1,
                       input logic [31:0] d2, input logic ordy, input logic fl);
    in_valid  = v;
    instr     = ins;
    rd_data1  = d1;
    rd_data2  = d2;
    out_ready = ordy;
    flush     = fl;
  endtask

  localparam logic [31:0] ADD_3_1_2  = 32'h0022_1820;
  localparam logic [31:0] LW_4_8_1   = 32'h8C24_0008;
  localparam logic [31:0] ADD_5_4_2  = 32'h0082_2820;
  localparam logic [31:0] ADDI_2_1_N = 32'h2022_FFFC;
  localparam logic [31:0] LW_0_0_1   = 32'h8C20_0000;
  localparam logic [31:0] ADD_6_0_0  = 32'h0000_3020;

  initial begin
    reset = 1'b1;
    wb_we = 1'b0;
    wb_reg = 5'd0;
    wb_data = 32'd0;
    apply(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_wr", out_wr, 32'd0);
    check("rst_stall", stall_count, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 32'd1);

    // add $3,$1,$2
    apply(1'b1, ADD_3_1_2, 32'd5, 32'd7, 1'b1, 1'b0);
    tick();
    check("add_valid", out_valid, 32'd1);
    check("add_a", out_a, 32'd5);
    check("add_b", out_b, 32'd7);
    check("add_wr", out_wr, 32'd3);
    check("add_mr", out_mr, 32'd0);

    // lw $4,8($1) then dependent add $5,$4,$2: one bubble
    apply(1'b1, LW_4_8_1, 32'd100, 32'd0, 1'b1, 1'b0);
    tick();
    check("lw_mr", out_mr, 32'd1);
    apply(1'b1, ADD_5_4_2, 32'd40, 32'd7, 1'b1, 1'b0);
    #1;
    check("hazard_in_ready", in_ready, 32'd0);
    tick();
    check("bubble_valid", out_valid, 32'd0);
    check("bubble_stall", stall_count, 32'd1);
    check("bubble_in_ready", in_ready, 32'd1);
    tick();
    check("dep_valid", out_valid, 32'd1);
    check("dep_wr", out_wr, 32'd5);

    // back-pressure for 3 cycles
    apply(1'b1, ADDI_2_1_N, 32'd11, 32'd22, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 32'd0);
      tick();
      check("bp_valid", out_valid, 32'd1);
      check("bp_wr", out_wr, 32'd5);
    end
    out_ready = 1'b1;
    tick();
    check("addi_imm", out_imm, 32'hFFFF_FFFC);
    check("addi_wr", out_wr, 32'd2);

    // flush while holding and fetch presenting
    apply(1'b1, ADD_3_1_2, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    check("flush_valid", out_valid, 32'd0);
    apply(1'b0, ADD_3_1_2, 32'd5, 32'd7, 1'b1, 1'b0);
    tick();
    check("flush_not_captured", out_valid, 32'd0);

    // load to $0 never stalls
    apply(1'b1, LW_0_0_1, 32'd1, 32'd0, 1'b1, 1'b0);
    tick();
    apply(1'b1, ADD_6_0_0, 32'd0, 32'd0, 1'b1, 1'b0);
    #1;
    check("r0_in_ready", in_ready, 32'd1);
    tick();
    check("r0_valid", out_valid, 32'd1);
    check("r0_wr", out_wr, 32'd6);
    check("r0_stall", stall_count, 32'd1);

    // writeback forwarding into rs
    wb_we = 1'b1;
    wb_reg = 5'd1;
    wb_data = 32'd99;
    apply(1'b1, ADD_3_1_2, 32'd5, 32'd7, 1'b1, 1'b0);
    tick();
    check("fwd_hit_a", out_a, FWD ? 32'd99 : 32'd5);
    wb_reg = 5'd0;
    tick();
    check("fwd_r0_a", out_a, 32'd5);
    wb_we = 1'b0;

    // reset while holding a load
    apply(1'b1, LW_4_8_1, 32'd100, 32'd0, 1'b1, 1'b0);
    tick();
    apply(1'b0, LW_4_8_1, 32'd100, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_valid", out_valid, 32'd0);
    check("midrst_opcode", out_opcode, 32'd0);
    check("midrst_stall", stall_count, 32'd0);
    reset = 1'b0;

    // long stall: counter must saturate
    apply(1'b1, LW_4_8_1, 32'd100, 32'd0, 1'b1, 1'b0);
    tick();
    apply(1'b1, ADD_5_4_2, 32'd40, 32'd7, 1'b0, 1'b0);
    repeat (70000) tick();
    check("sat_stall", stall_count, 32'h0000_FFFF);
    out_ready = 1'b1;
    tick();
    check("sat_bubble", out_valid, 32'd0);
    check("sat_hold", stall_count, 32'h0000_FFFF);
    tick();
    check("sat_dep_valid", out_valid, 32'd1);
    check("sat_dep_rs", out_rs, 32'd4);
    apply(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
